// File: rtl/fir_filter.sv
// Direct-form N-tap FIR filter with live coefficient inputs.
// Three pipeline stages: tap line, P partial-sum groups, final accumulator.
module fir_filter #(
    parameter int BITWIDTH = 16,
    parameter int ACCWIDTH = 24,
    parameter int N        = 16,
    parameter int P        = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic signed [BITWIDTH-1:0] coeffs [N],
    input  logic signed [BITWIDTH-1:0] inP,
    output logic signed [BITWIDTH-1:0] outP
);

    localparam int GROUPSIZE = N / P;

    logic signed [BITWIDTH-1:0] tapLine_q  [N];
    logic signed [ACCWIDTH-1:0] groupSum_q [P];
    logic signed [ACCWIDTH-1:0] groupSum_d [P];
    logic signed [ACCWIDTH-1:0] acc_q;
    logic signed [ACCWIDTH-1:0] acc_d;
    logic                       unusedAccBits;

    // Products are formed at full 2*BITWIDTH precision, then only the low
    // ACCWIDTH bits are kept; all sums wrap modulo 2^ACCWIDTH.
    always_comb begin
        logic signed [2*BITWIDTH-1:0] coeffExt;
        logic signed [2*BITWIDTH-1:0] tapExt;
        logic signed [ACCWIDTH-1:0]   product;
        for (int j = 0; j < P; j++) begin
            groupSum_d[j] = '0;
        end
        acc_d = '0;
        for (int j = 0; j < P; j++) begin
            for (int i = 0; i < GROUPSIZE; i++) begin
                coeffExt      = (2*BITWIDTH)'(coeffs[j*GROUPSIZE + i]);
                tapExt        = (2*BITWIDTH)'(tapLine_q[j*GROUPSIZE + i]);
                product       = ACCWIDTH'(coeffExt * tapExt);
                groupSum_d[j] = groupSum_d[j] + product;
            end
            acc_d = acc_d + groupSum_q[j];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                tapLine_q[k] <= '0;
            end
            for (int j = 0; j < P; j++) begin
                groupSum_q[j] <= '0;
            end
            acc_q <= '0;
        end else if (enable) begin
            tapLine_q[0] <= inP;
            for (int k = 1; k < N; k++) begin
                tapLine_q[k] <= tapLine_q[k-1];
            end
            for (int j = 0; j < P; j++) begin
                groupSum_q[j] <= groupSum_d[j];
            end
            acc_q <= acc_d;
        end
    end

    // The fractional low bits of the accumulator are dropped at the output.
    assign outP          = acc_q[ACCWIDTH-1 -: BITWIDTH];
    assign unusedAccBits = ^acc_q;

endmodule

// File: tb/tb_fir_filter.sv
// Directed self-checking bench for fir_filter: impulse, step, negative,
// wrap-around, stall and mid-stream reset with hand-computed outputs.
module tb_fir_filter;

    logic               clk;
    logic               reset;
    logic               enable;
    logic signed [15:0] coeffs [16];
    logic signed [15:0] inP;
    logic signed [15:0] outP;

    int checks   = 0;
    int failures = 0;

    fir_filter #(
        .BITWIDTH(16),
        .ACCWIDTH(24),
        .N(16),
        .P(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .coeffs(coeffs),
        .inP(inP),
        .outP(outP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, let one rising edge pass, then settle before sampling.
    task automatic applyStimulus(input logic signed [15:0] sample,
                                 input logic en, input logic rst);
        inP    = sample;
        enable = en;
        reset  = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag,
                               input logic signed [15:0] observed,
                               input logic signed [15:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
                     tag, observed, observed, expected, expected);
        end
    endtask

    task automatic setRampCoeffs();
        for (int k = 0; k < 16; k++) coeffs[k] = 16'(k);
    endtask

    task automatic setFlatCoeffs(input logic signed [15:0] value);
        for (int k = 0; k < 16; k++) coeffs[k] = value;
    endtask

    // Reset, capture one 256 sample, and pass the first post-capture edge.
    task automatic startImpulse(input string name);
        setRampCoeffs();
        applyStimulus(16'sd0, 1'b1, 1'b1);
        checkOutput($sformatf("%s_reset", name), outP, 16'sd0);
        applyStimulus(16'sd256, 1'b1, 1'b0);
        applyStimulus(16'sd0, 1'b1, 1'b0);
        checkOutput($sformatf("%s_t1", name), outP, 16'sd0);
    endtask

    initial begin
        logic [23:0] wrapAcc;
        inP    = '0;
        enable = 1'b0;
        reset  = 1'b1;
        setRampCoeffs();

        $display("[TB] impulse");
        startImpulse("imp");
        for (int k = 0; k <= 16; k++) begin
            applyStimulus(16'sd0, 1'b1, 1'b0);
            checkOutput($sformatf("imp_%0d", k), outP, (k < 16) ? 16'(k) : 16'sd0);
        end

        $display("[TB] step");
        setRampCoeffs();
        applyStimulus(16'sd0, 1'b1, 1'b1);
        applyStimulus(16'sd256, 1'b1, 1'b0);
        applyStimulus(16'sd256, 1'b1, 1'b0);
        for (int m = 0; m < 20; m++) begin
            applyStimulus(16'sd256, 1'b1, 1'b0);
            checkOutput($sformatf("step_%0d", m), outP,
                        (m < 15) ? 16'((m * (m + 1)) / 2) : 16'sd120);
        end

        $display("[TB] negative");
        setFlatCoeffs(16'sd1);
        applyStimulus(16'sd0, 1'b1, 1'b1);
        applyStimulus(-16'sd256, 1'b1, 1'b0);
        applyStimulus(-16'sd256, 1'b1, 1'b0);
        for (int m = 0; m < 20; m++) begin
            applyStimulus(-16'sd256, 1'b1, 1'b0);
            checkOutput($sformatf("neg_%0d", m), outP,
                        (m < 15) ? 16'(-(m + 1)) : -16'sd16);
        end

        $display("[TB] wrap");
        setFlatCoeffs(16'sh7FFF);
        applyStimulus(16'sd0, 1'b1, 1'b1);
        applyStimulus(16'sh7FFF, 1'b1, 1'b0);
        applyStimulus(16'sh7FFF, 1'b1, 1'b0);
        for (int m = 0; m < 20; m++) begin
            applyStimulus(16'sh7FFF, 1'b1, 1'b0);
            wrapAcc = 24'((m + 1) * 24'hFF0001);
            if (m >= 15) wrapAcc = 24'hF00010;
            checkOutput($sformatf("wrap_%0d", m), outP, wrapAcc[23:8]);
        end

        $display("[TB] stall");
        startImpulse("stall");
        for (int k = 0; k <= 5; k++) begin
            applyStimulus(16'sd0, 1'b1, 1'b0);
            checkOutput($sformatf("stall_pre_%0d", k), outP, 16'(k));
        end
        for (int s = 0; s < 3; s++) begin
            applyStimulus(16'sd256, 1'b0, 1'b0);
            checkOutput($sformatf("stall_hold_%0d", s), outP, 16'sd5);
        end
        for (int k = 6; k <= 16; k++) begin
            applyStimulus(16'sd0, 1'b1, 1'b0);
            checkOutput($sformatf("stall_post_%0d", k), outP, (k < 16) ? 16'(k) : 16'sd0);
        end

        $display("[TB] mid-stream reset");
        startImpulse("rst");
        for (int k = 0; k <= 7; k++) begin
            applyStimulus(16'sd0, 1'b1, 1'b0);
            checkOutput($sformatf("rst_pre_%0d", k), outP, 16'(k));
        end
        applyStimulus(16'sd0, 1'b1, 1'b1);
        checkOutput("rst_edge", outP, 16'sd0);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(16'sd0, 1'b1, 1'b0);
            checkOutput($sformatf("rst_after_%0d", k), outP, 16'sd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
